// File: rtl/lt24_multi_timer_if.sv
// -----------------------------------------------------------------------------
// lt24_multi_timer_if
// Avalon-MM slave bus bundle for the LT24 multi-channel timer.
//   chipselect : slave select
//   address    : word address, [AW-1:2] channel, [1:0] register
//   write_n    : active-low write strobe, qualified by chipselect
//   writedata  : 32-bit write data
//   readdata   : 32-bit registered read data
// Modports: master (bus initiator), slave (timer side).
// -----------------------------------------------------------------------------
interface lt24_multi_timer_if #(
    parameter int AW = 4
);
    logic          chipselect;
    logic [AW-1:0] address;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;

    modport master (
        output chipselect,
        output address,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  chipselect,
        input  address,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/lt24_multi_timer.sv
// -----------------------------------------------------------------------------
// lt24_multi_timer
// NUM_CH independent COUNT_W-bit down-counters on an Avalon-MM slave, each with
// an 8-bit prescaler, one-shot/continuous mode, snapshot capture and a sticky
// timeout flag.
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : Avalon-MM slave (lt24_multi_timer_if.slave)
//   irq      : OR of irq_vec
//   irq_vec  : per-channel interrupt, TO & ITO
// Register map per channel (offset): 0 STATUS {RUN,TO}, 1 CONTROL
// {PRESCALE[15:8], CASCADE[4], STOP[3], START[2], CONT[1], ITO[0]},
// 2 PERIOD, 3 SNAPSHOT.
// Optional feature macro: LT24_TIMER_CASCADE_EN -- when defined, CONTROL bit4 on
// channel n>0 replaces that channel's tick with the timeout event of channel
// n-1. When undefined, bit4 is not stored and reads 0.
// -----------------------------------------------------------------------------
module lt24_multi_timer #(
    parameter int          NUM_CH         = 2,
    parameter int          COUNT_W        = 32,
    parameter logic [31:0] DEFAULT_PERIOD = 32'h0001387F,
    parameter int          AW             = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    lt24_multi_timer_if.slave bus,
    output logic              irq,
    output logic [NUM_CH-1:0] irq_vec
);
    localparam logic [COUNT_W-1:0] DEF_PERIOD = DEFAULT_PERIOD[COUNT_W-1:0];
    localparam logic [COUNT_W-1:0] CNT_ZERO   = {COUNT_W{1'b0}};
    localparam logic [COUNT_W-1:0] CNT_ONE    = {{(COUNT_W-1){1'b0}}, 1'b1};

    logic [AW-1:0]      addr_s;
    logic [AW-1:0]      ch_idx_s;
    logic [1:0]         reg_s;
    logic               wr_s;
    logic [31:0]        rd_mux_s;

    logic [NUM_CH-1:0]  timeout_s;
    logic [NUM_CH-1:0]  to_s;
    logic [NUM_CH-1:0]  run_s;
    logic [NUM_CH-1:0]  ito_s;
    logic [NUM_CH-1:0]  cont_s;
    logic [NUM_CH-1:0]  casc_s;
    logic [7:0]         presc_s  [NUM_CH];
    logic [COUNT_W-1:0] period_s [NUM_CH];
    logic [COUNT_W-1:0] snap_s   [NUM_CH];

    assign addr_s   = bus.address;
    assign ch_idx_s = addr_s >> 2'd2;
    assign reg_s    = addr_s[1:0];
    assign wr_s     = bus.chipselect & ~bus.write_n;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        localparam logic [AW-1:0] CH_ADDR = AW'(g);

        logic               sel_s;
        logic               wr_status_s;
        logic               wr_control_s;
        logic               wr_period_s;
        logic               wr_snap_s;
        logic               presc_hit_s;
        logic               tick_s;
        logic               to_r;
        logic               run_r;
        logic               ito_r;
        logic               cont_r;
        logic               prev_nz_r;
        logic               reload_r;
        logic [7:0]         presc_r;
        logic [7:0]         pcnt_r;
        logic [COUNT_W-1:0] period_r;
        logic [COUNT_W-1:0] counter_r;
        logic [COUNT_W-1:0] snap_r;

        assign sel_s        = wr_s && (ch_idx_s == CH_ADDR);
        assign wr_status_s  = sel_s && (reg_s == 2'd0);
        assign wr_control_s = sel_s && (reg_s == 2'd1);
        assign wr_period_s  = sel_s && (reg_s == 2'd2);
        assign wr_snap_s    = sel_s && (reg_s == 2'd3);

        // A timeout is the first cycle the counter sits at zero, so a counter
        // parked at zero (PERIOD=0) raises exactly one event.
        assign timeout_s[g] = (counter_r == CNT_ZERO) && prev_nz_r;
        assign presc_hit_s  = (pcnt_r == presc_r);

`ifdef LT24_TIMER_CASCADE_EN
        logic casc_r;

        if (g > 0) begin : g_link
            assign tick_s = run_r && (casc_r ? timeout_s[g-1] : presc_hit_s);
        end else begin : g_head
            assign tick_s = run_r && presc_hit_s;
        end

        // Cascade select, written with the rest of CONTROL
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                casc_r <= 1'b0;
            end else if (wr_control_s) begin
                casc_r <= bus.writedata[4];
            end else begin
                casc_r <= casc_r;
            end
        end

        assign casc_s[g] = casc_r;
`else
        assign tick_s    = run_r && presc_hit_s;
        assign casc_s[g] = 1'b0;
`endif

        // Channel state: prescaler, counter, run/timeout flags and registers
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                to_r      <= 1'b0;
                run_r     <= 1'b0;
                ito_r     <= 1'b0;
                cont_r    <= 1'b0;
                prev_nz_r <= (DEF_PERIOD != CNT_ZERO);
                reload_r  <= 1'b0;
                presc_r   <= 8'd0;
                pcnt_r    <= 8'd0;
                period_r  <= DEF_PERIOD;
                counter_r <= DEF_PERIOD;
                snap_r    <= CNT_ZERO;
            end else begin
                prev_nz_r <= (counter_r != CNT_ZERO);
                reload_r  <= wr_period_s;

                // Prescaler restarts from 0 whenever the channel is idle or reloaded
                if (!run_r || reload_r || presc_hit_s) begin
                    pcnt_r <= 8'd0;
                end else begin
                    pcnt_r <= pcnt_r + 8'd1;
                end

                // The forced reload after a PERIOD write overrides counting
                if (reload_r) begin
                    counter_r <= period_r;
                end else if (tick_s) begin
                    counter_r <= (counter_r == CNT_ZERO) ? period_r : (counter_r - CNT_ONE);
                end else begin
                    counter_r <= counter_r;
                end

                // START beats STOP in the same write
                if (wr_control_s && bus.writedata[2]) begin
                    run_r <= 1'b1;
                end else if (wr_control_s && bus.writedata[3]) begin
                    run_r <= 1'b0;
                end else if (wr_period_s) begin
                    run_r <= 1'b0;
                end else if (tick_s && (counter_r == CNT_ZERO) && !cont_r) begin
                    run_r <= 1'b0;
                end else begin
                    run_r <= run_r;
                end

                // A coincident timeout beats the software clear so no event is lost
                if (timeout_s[g]) begin
                    to_r <= 1'b1;
                end else if (wr_status_s) begin
                    to_r <= 1'b0;
                end else begin
                    to_r <= to_r;
                end

                if (wr_control_s) begin
                    ito_r   <= bus.writedata[0];
                    cont_r  <= bus.writedata[1];
                    presc_r <= bus.writedata[15:8];
                end else begin
                    ito_r   <= ito_r;
                    cont_r  <= cont_r;
                    presc_r <= presc_r;
                end

                if (wr_period_s) begin
                    period_r <= bus.writedata[COUNT_W-1:0];
                end else begin
                    period_r <= period_r;
                end

                if (wr_snap_s) begin
                    snap_r <= counter_r;
                end else begin
                    snap_r <= snap_r;
                end
            end
        end

        assign to_s[g]     = to_r;
        assign run_s[g]    = run_r;
        assign ito_s[g]    = ito_r;
        assign cont_s[g]   = cont_r;
        assign presc_s[g]  = presc_r;
        assign period_s[g] = period_r;
        assign snap_s[g]   = snap_r;
    end

    // Read mux; unimplemented channel indexes fall through to zero
    always_comb begin
        rd_mux_s = 32'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_idx_s == AW'(i)) begin
                case (reg_s)
                    2'd0:    rd_mux_s = {30'd0, run_s[i], to_s[i]};
                    2'd1:    rd_mux_s = {16'd0, presc_s[i], 3'd0, casc_s[i], 2'd0, cont_s[i], ito_s[i]};
                    2'd2:    rd_mux_s = 32'(period_s[i]);
                    2'd3:    rd_mux_s = 32'(snap_s[i]);
                    default: rd_mux_s = 32'd0;
                endcase
            end else begin
                rd_mux_s = rd_mux_s;
            end
        end
    end

    // Read data register, refreshed every cycle regardless of chipselect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= 32'd0;
        end else begin
            bus.readdata <= rd_mux_s;
        end
    end

    assign irq_vec = to_s & ito_s;
    assign irq     = |irq_vec;
endmodule
